// File: rtl/spi_mem_host_if.sv
// Request-side and serial-side signals of the spi_mem command host.
// No logic of its own; carries the handshake between requester, host and spi_mem.
// Backpressure is busy (requester side) and ready/op_done (memory side).
interface spi_mem_host_if;
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       cs;
    logic       miso;
    logic       mosi;
    logic       ready;
    logic       op_done;

    // The host itself.
    modport slave (
        input  req, wr, addr, wdata, mosi, ready, op_done,
        output busy, done, err, rdata, cs, miso
    );

    // Whoever drives requests and plays the memory side.
    modport master (
        output req, wr, addr, wdata, mosi, ready, op_done,
        input  busy, done, err, rdata, cs, miso
    );
endinterface

// File: rtl/spi_mem_host.sv
// Serialises one read/write request into a spi_mem frame and returns the result.
// Latency: write done after edge A+20, read after A+21 with a prompt spi_mem; range error after A.
// Backpressure: one request in flight, req ignored while busy; ready/op_done waits bounded by TIMEOUT.
module spi_mem_host #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    spi_mem_host_if.slave bus
);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]      DEPTH_W  = 9'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        OPBIT,
        ADDR,
        WDATA,
        STOP,
        WAIT_RDY,
        RECV,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            cs_q, cs_d;
    logic            miso_q, miso_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      rsh_q, rsh_d;
    logic [2:0]      bit_q, bit_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            wr_q, wr_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;

    assign bus.cs    = cs_q;
    assign bus.miso  = miso_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    // State and datapath registers; everything returns to idle on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rsh_q   <= '0;
            bit_q   <= '0;
            tmo_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rsh_q   <= rsh_d;
            bit_q   <= bit_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        miso_d  = miso_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        rsh_d   = rsh_q;
        bit_d   = bit_q;
        tmo_d   = tmo_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req && !busy_q) begin
                    if ({1'b0, bus.addr} >= DEPTH_W) begin
                        // Out-of-range: answer immediately, never touch the memory.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        cs_d    = 1'b0;
                        miso_d  = 1'b0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        wr_d    = bus.wr;
                        addr_d  = bus.addr;
                        wdata_d = bus.wdata;
                        bit_d   = '0;
                        state_d = OPBIT;
                    end
                end
            end
            OPBIT: begin
                miso_d  = wr_q;
                bit_d   = '0;
                state_d = ADDR;
            end
            ADDR: begin
                miso_d = addr_q[bit_q];
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = wr_q ? WDATA : STOP;
                end
            end
            WDATA: begin
                miso_d = wdata_q[bit_q];
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Raising cs ends the frame; spi_mem then runs the operation.
                cs_d    = 1'b1;
                miso_d  = 1'b0;
                tmo_d   = '0;
                state_d = wr_q ? WAIT_DONE : WAIT_RDY;
            end
            WAIT_RDY: begin
                if (bus.op_done) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.ready) begin
                    rsh_d[0] = bus.mosi;
                    bit_d    = 3'd1;
                    state_d  = RECV;
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RECV: begin
                // Once ready has been seen the remaining bits follow back to back.
                if (bus.op_done) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rsh_d[bit_q] = bus.mosi;
                    bit_d        = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tmo_d   = '0;
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.op_done) begin
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    if (!wr_q) begin
                        rdata_d = rsh_q;
                    end
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_spi_mem_host.sv
// Bench for spi_mem_host: behavioural spi_mem responder plus a request-level reference model.
// Fixed vector table, hand sequences for reset/back-to-back, then randomized requests.
// Responder can answer normally, stay silent, or raise op_done early.
module tb_spi_mem_host;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 64;
    localparam int LIMIT   = 200;
    localparam int M_NORM  = 0;
    localparam int M_SIL   = 1;
    localparam int M_PROTO = 2;

    logic clk;
    logic rst_n;
    spi_mem_host_if bus();

    spi_mem_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int resp_mode = M_NORM;

    logic [7:0] ref_mem [0:DEPTH-1];
    logic [7:0] rd_last;

    task automatic check(input string nm, input int got, input int exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    // Request-level model: outcome of a request from the address range, responder mode and memory.
    function automatic void model(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                                  input int mode, output int lat, output bit err,
                                  output logic [7:0] rd);
        if (int'(a) >= DEPTH) begin
            lat = 0; err = 1'b1;
        end else if (mode == M_SIL) begin
            lat = (wr ? 18 : 10) + TIMEOUT; err = 1'b1;
        end else if (mode == M_PROTO && !wr) begin
            lat = 12; err = 1'b1;
        end else begin
            lat = wr ? 20 : 21; err = 1'b0;
            if (wr) ref_mem[a[4:0]] = wd;
            else    rd_last = ref_mem[a[4:0]];
        end
        rd = rd_last;
    endfunction

    // Behavioural spi_mem: collects the frame while cs is low, then answers.
    logic [7:0] smem [0:DEPTH-1];
    initial begin
        bit fb[$];
        logic [7:0] a, wd, d;
        bus.mosi = 1'b0; bus.ready = 1'b0; bus.op_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) smem[i] = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.cs === 1'b0) begin
                fb.delete();
                forever begin
                    @(posedge clk); #1;
                    if (bus.cs !== 1'b0) break;
                    fb.push_back(bus.miso);
                end
                a = '0; wd = '0;
                if (fb.size() >= 9) for (int i = 0; i < 8; i++) a[i] = fb[1+i];
                if (fb.size() == 17) for (int i = 0; i < 8; i++) wd[i] = fb[9+i];
                if (resp_mode == M_SIL || rst_n !== 1'b1) begin
                    // no answer
                end else if (fb.size() == 17 && fb[0] == 1'b1) begin
                    smem[a[4:0]] = wd;
                    @(posedge clk); #1; bus.op_done = 1'b1;
                    @(posedge clk); #1; bus.op_done = 1'b0;
                end else if (fb.size() == 9 && fb[0] == 1'b0) begin
                    if (resp_mode == M_PROTO) begin
                        @(posedge clk); #1; bus.op_done = 1'b1;
                        @(posedge clk); #1; bus.op_done = 1'b0;
                    end else begin
                        d = smem[a[4:0]];
                        @(posedge clk); #1;
                        @(posedge clk); #1; bus.ready = 1'b1; bus.mosi = d[0];
                        for (int i = 1; i < 8; i++) begin
                            @(posedge clk); #1; bus.ready = 1'b0; bus.mosi = d[i];
                        end
                        @(posedge clk); #1; bus.op_done = 1'b1; bus.mosi = 1'b0;
                        @(posedge clk); #1; bus.op_done = 1'b0;
                    end
                end
            end
        end
    end

    // One request: checks busy at accept, frame bits, done latency, err, rdata, done width.
    task automatic run_txn(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                           input int lat_e, input bit err_e, input logic [7:0] rd_e,
                           input string nm);
        bit q_got[$];
        bit q_exp[$];
        int cs_low = 0;
        int lat = -1;
        int cs_e;
        bit err_g = 1'b0;
        logic [7:0] rd_g = '0;
        bit in_rng;
        in_rng = (int'(a) < DEPTH);
        @(negedge clk);
        bus.req = 1'b1; bus.wr = wr; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check({nm, " busy_at_accept"}, int'(bus.busy), int'(in_rng));
        for (int k = 0; k <= LIMIT; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus.cs === 1'b0) begin
                cs_low++;
                if (k >= 1) q_got.push_back(bus.miso);
            end
            if (bus.done === 1'b1) begin
                lat = k; err_g = bus.err; rd_g = bus.rdata;
                break;
            end
        end
        if (in_rng) begin
            q_exp.push_back(wr);
            for (int i = 0; i < 8; i++) q_exp.push_back(a[i]);
            if (wr) for (int i = 0; i < 8; i++) q_exp.push_back(wd[i]);
        end
        cs_e = in_rng ? (wr ? 18 : 10) : 0;
        check({nm, " cs_low_cycles"}, cs_low, cs_e);
        check({nm, " frame"}, int'(q_got == q_exp), 1);
        check({nm, " latency"}, lat, lat_e);
        check({nm, " err"}, int'(err_g), int'(err_e));
        check({nm, " rdata"}, int'(rd_g), int'(rd_e));
        @(posedge clk); #1;
        check({nm, " done_width"}, int'(bus.done), 0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         mode;
        int         lat;
        bit         err;
        logic [7:0] rd;
    } vec_t;

    initial begin
        vec_t vt [12];
        int   lat_m;
        bit   err_m;
        logic [7:0] rd_m;
        int   dq[$];
        int   nbl;
        int   seen;

        vt[0]  = '{1'b1, 8'd5,   8'hA5, M_NORM,  20, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 8'd5,   8'h00, M_NORM,  21, 1'b0, 8'hA5};
        vt[2]  = '{1'b1, 8'd31,  8'hFF, M_NORM,  20, 1'b0, 8'hA5};
        vt[3]  = '{1'b0, 8'd31,  8'h00, M_NORM,  21, 1'b0, 8'hFF};
        vt[4]  = '{1'b0, 8'd0,   8'h00, M_NORM,  21, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 8'd32,  8'h00, M_NORM,   0, 1'b1, 8'h00};
        vt[6]  = '{1'b1, 8'd255, 8'h12, M_NORM,   0, 1'b1, 8'h00};
        vt[7]  = '{1'b0, 8'd5,   8'h00, M_SIL,   74, 1'b1, 8'h00};
        vt[8]  = '{1'b0, 8'd31,  8'h00, M_PROTO, 12, 1'b1, 8'h00};
        vt[9]  = '{1'b1, 8'd7,   8'h5A, M_SIL,   82, 1'b1, 8'h00};
        vt[10] = '{1'b0, 8'd5,   8'h00, M_NORM,  21, 1'b0, 8'hA5};
        vt[11] = '{1'b0, 8'd7,   8'h00, M_NORM,  21, 1'b0, 8'h00};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        rd_last = 8'h00;
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset values while held in reset across a clock edge.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cs", int'(bus.cs), 1);
        check("reset miso", int'(bus.miso), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset err", int'(bus.err), 0);
        check("reset rdata", int'(bus.rdata), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            resp_mode = vt[i].mode;
            model(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].mode, lat_m, err_m, rd_m);
            run_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].err, vt[i].rd,
                    $sformatf("vec%0d", i));
        end
        resp_mode = M_NORM;

        // Asynchronous reset in the middle of a write frame.
        @(negedge clk);
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 8'd9; bus.wdata = 8'h3C;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset cs", int'(bus.cs), 1);
        check("midreset busy", int'(bus.busy), 0);
        check("midreset done", int'(bus.done), 0);
        check("midreset rdata", int'(bus.rdata), 0);
        rd_last = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check("midreset no_done", seen, 0);
        model(1'b0, 8'd9, 8'h00, M_NORM, lat_m, err_m, rd_m);
        run_txn(1'b0, 8'd9, 8'h00, lat_m, err_m, rd_m, "after_reset_read9");

        // req held high: back-to-back reads, each accepted on the cycle after done.
        @(negedge clk);
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 8'd5;
        nbl = 0;
        for (int k = 0; k <= 70; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dq.push_back(k);
                check($sformatf("b2b rdata k%0d", k), int'(bus.rdata), int'(ref_mem[5]));
                check($sformatf("b2b err k%0d", k), int'(bus.err), 0);
            end
            if (bus.busy === 1'b0) nbl++;
        end
        @(negedge clk); bus.req = 1'b0;
        check("b2b done_count", dq.size(), 3);
        for (int i = 0; i < dq.size() && i < 3; i++)
            check($sformatf("b2b done_pos%0d", i), dq[i], 21 + 22 * i);
        check("b2b idle_cycles", nbl, 3);
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1;
        end
        check("b2b last_done", seen, 1);
        model(1'b0, 8'd5, 8'h00, M_NORM, lat_m, err_m, rd_m);
        repeat (2) @(posedge clk);

        // Randomized requests against the model.
        for (int i = 0; i < 30; i++) begin
            bit wr_r;
            logic [7:0] a_r, wd_r;
            int m_r;
            int sel;
            wr_r = 1'($urandom_range(0, 1));
            a_r  = 8'($urandom_range(0, 39));
            wd_r = 8'($urandom_range(0, 255));
            sel  = $urandom_range(0, 9);
            m_r  = (sel == 0) ? M_SIL : (sel == 1) ? M_PROTO : M_NORM;
            resp_mode = m_r;
            model(wr_r, a_r, wd_r, m_r, lat_m, err_m, rd_m);
            run_txn(wr_r, a_r, wd_r, lat_m, err_m, rd_m, $sformatf("rnd%0d", i));
        end
        resp_mode = M_NORM;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Watchdog: a stuck run still reports before stopping.
    initial begin
        #500000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
